// File: rtl/inv_shift_sub_bytes_if.sv
// Handshake bundle for the AES InvShiftRows + InvSubBytes stage.
// The upstream side carries in_valid/in_ready/state_in; the downstream side carries out_valid/out_ready/state_out.
interface inv_shift_sub_bytes_if #(
    parameter int WORD_SIZE  = 8,
    parameter int ARRAY_SIZE = 16
);
    logic                              in_valid;
    logic                              in_ready;
    logic [WORD_SIZE*ARRAY_SIZE-1:0]   state_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [WORD_SIZE*ARRAY_SIZE-1:0]   state_out;
    logic                              busy;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/inv_shift_sub_bytes.sv
// Sequential AES-128 InvShiftRows + InvSubBytes: one output column per cycle
// through four inverse S-box lookups, valid/ready on both sides.
module inv_shift_sub_bytes (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_shift_sub_bytes_if.slave bus_if
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    stateT          state_q, state_d;
    logic [1:0]     col_q, col_d;
    logic [127:0]   buffer_q, buffer_d;
    logic [127:0]   state_out_q, state_out_d;
    logic [7:0]     colBytes [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            buffer_q    <= '0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            buffer_q    <= buffer_d;
            state_out_q <= state_out_d;
        end
    end

    // Output row r of column col comes from buffer column (col - r) mod 4, which the 2-bit subtraction wraps for free.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [1:0] srcCol;
            srcCol      = col_q - 2'(r);
            colBytes[r] = invSbox(buffer_q[(15 - (int'(srcCol) * 4 + r)) * 8 +: 8]);
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        buffer_d    = buffer_q;
        state_out_d = state_out_q;
        case (state_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    buffer_d = bus_if.state_in;
                    col_d    = 2'd0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                for (int r = 0; r < 4; r++) begin
                    state_out_d[(15 - (int'(col_q) * 4 + r)) * 8 +: 8] = colBytes[r];
                end
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DONE: begin
                if (bus_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.in_ready  = (state_q == IDLE);
    assign bus_if.out_valid = (state_q == DONE);
    assign bus_if.busy      = (state_q == BUSY) || (state_q == DONE);
    assign bus_if.state_out = state_out_q;
endmodule
